// File: rtl/px_ss_csr_bank_pkg.sv
// Shared definitions for the pixel-subsampler CSR bank: response codes,
// APPLY register layout and the word-address decoder.
package px_ss_csr_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int APPLY_REQ_BIT  = 0;
    localparam int APPLY_MODE_BIT = 1;
    localparam int APPLY_PEND_BIT = 2;

    // 64 control + APPLY + 64 status indices fit in 8 bits
    localparam int IDX_W = 8;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } addr_dec_t;

    function automatic addr_dec_t addr_decode(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned nregs);
        addr_dec_t   d;
        logic [31:0] off;
        off   = addr - base;
        d.idx = off[IDX_W+1:2];
        d.hit = (addr >= base) && ({2'b00, off[31:2]} < nregs);
        return d;
    endfunction

endpackage

// File: rtl/px_ss_axil_fe.sv
// AXI4-Lite front end: independent AW/W capture, single-cycle write commit,
// registered read response. Register storage lives in the parent.
module px_ss_axil_fe
    import px_ss_csr_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NREGS     = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      csr_awaddr,
    input  logic             csr_awvalid,
    output logic             csr_awready,
    input  logic [31:0]      csr_wdata,
    input  logic [3:0]       csr_wstrb,
    input  logic             csr_wvalid,
    output logic             csr_wready,
    output logic [1:0]       csr_bresp,
    output logic             csr_bvalid,
    input  logic             csr_bready,
    input  logic [31:0]      csr_araddr,
    input  logic             csr_arvalid,
    output logic             csr_arready,
    output logic [31:0]      csr_rdata,
    output logic [1:0]       csr_rresp,
    output logic             csr_rvalid,
    input  logic             csr_rready,
    output logic             wr_en,
    output logic             wr_hit,
    output logic [IDX_W-1:0] wr_idx,
    output logic [31:0]      wr_data,
    output logic [3:0]       wr_strb,
    output logic             rd_hit,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [31:0]      rd_data,
    input  logic [1:0]       rd_resp
);

    logic        aw_held;
    logic        w_held;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic [31:0] wr_addr;
    addr_dec_t   wr_dec;
    addr_dec_t   rd_dec;

    assign csr_awready = !aw_held && !csr_bvalid;
    assign csr_wready  = !w_held && !csr_bvalid;
    assign csr_arready = !csr_rvalid;

    assign aw_hs = csr_awvalid && csr_awready;
    assign w_hs  = csr_wvalid && csr_wready;
    assign ar_hs = csr_arvalid && csr_arready;

    // A channel arriving this cycle is used directly so a joint AW+W
    // handshake commits without first parking in the holding registers.
    assign wr_en   = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_addr = aw_held ? awaddr_q : csr_awaddr;
    assign wr_data = w_held ? wdata_q : csr_wdata;
    assign wr_strb = w_held ? wstrb_q : csr_wstrb;

    assign wr_dec = addr_decode(wr_addr, BASE_ADDR, NREGS);
    assign wr_hit = wr_dec.hit;
    assign wr_idx = wr_dec.idx;

    assign rd_dec = addr_decode(csr_araddr, BASE_ADDR, NREGS);
    assign rd_hit = rd_dec.hit;
    assign rd_idx = rd_dec.idx;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            csr_bvalid <= 1'b0;
            csr_bresp  <= RESP_OKAY;
        end else begin
            if (csr_bvalid && csr_bready) begin
                csr_bvalid <= 1'b0;
                csr_bresp  <= RESP_OKAY;
            end
            if (wr_en) begin
                aw_held    <= 1'b0;
                w_held     <= 1'b0;
                csr_bvalid <= 1'b1;
                csr_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= csr_awaddr;
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= csr_wdata;
                    wstrb_q <= csr_wstrb;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            csr_rvalid <= 1'b0;
            csr_rdata  <= '0;
            csr_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            csr_rvalid <= 1'b1;
            csr_rdata  <= rd_data;
            csr_rresp  <= rd_resp;
        end else if (csr_rvalid && csr_rready) begin
            csr_rvalid <= 1'b0;
            csr_rdata  <= '0;
            csr_rresp  <= RESP_OKAY;
        end
    end

endmodule

// File: rtl/px_ss_csr_bank.sv
// CSR bank top: shadowed control registers, APPLY (immediate or
// start-of-frame synchronous) into the active set, and the read mux.
module px_ss_csr_bank
    import px_ss_csr_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CTRL_CNT  = 6,
    parameter int unsigned STAT_CNT  = 2,
    parameter int unsigned REG_W     = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [31:0]                         csr_awaddr,
    input  logic                                csr_awvalid,
    output logic                                csr_awready,
    input  logic [31:0]                         csr_wdata,
    input  logic [3:0]                          csr_wstrb,
    input  logic                                csr_wvalid,
    output logic                                csr_wready,
    output logic [1:0]                          csr_bresp,
    output logic                                csr_bvalid,
    input  logic                                csr_bready,
    input  logic [31:0]                         csr_araddr,
    input  logic                                csr_arvalid,
    output logic                                csr_arready,
    output logic [31:0]                         csr_rdata,
    output logic [1:0]                          csr_rresp,
    output logic                                csr_rvalid,
    input  logic                                csr_rready,
    input  logic                                sof_i,
    input  logic [(STAT_CNT>0?STAT_CNT:1)*32-1:0] stat_i,
    output logic [CTRL_CNT*REG_W-1:0]           ctrl_o,
    output logic                                apply_stb_o
);

    localparam int unsigned      NREGS     = CTRL_CNT + 1 + STAT_CNT;
    localparam logic [IDX_W-1:0] APPLY_IDX = IDX_W'(CTRL_CNT);

    logic             wr_en;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             rd_hit;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;
    logic [1:0]       rd_resp;

    logic [REG_W-1:0] shadow [CTRL_CNT];
    logic [REG_W-1:0] active [CTRL_CNT];
    logic [REG_W-1:0] wmask;
    logic             mode;
    logic             pending;
    logic             imm_q;
    logic             apply_wr;
    logic             apply_req;
    logic             apply_go;
    logic             unused_in;

    px_ss_axil_fe #(
        .BASE_ADDR (BASE_ADDR),
        .NREGS     (NREGS)
    ) u_fe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .csr_awaddr  (csr_awaddr),
        .csr_awvalid (csr_awvalid),
        .csr_awready (csr_awready),
        .csr_wdata   (csr_wdata),
        .csr_wstrb   (csr_wstrb),
        .csr_wvalid  (csr_wvalid),
        .csr_wready  (csr_wready),
        .csr_bresp   (csr_bresp),
        .csr_bvalid  (csr_bvalid),
        .csr_bready  (csr_bready),
        .csr_araddr  (csr_araddr),
        .csr_arvalid (csr_arvalid),
        .csr_arready (csr_arready),
        .csr_rdata   (csr_rdata),
        .csr_rresp   (csr_rresp),
        .csr_rvalid  (csr_rvalid),
        .csr_rready  (csr_rready),
        .wr_en       (wr_en),
        .wr_hit      (wr_hit),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .rd_hit      (rd_hit),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .rd_resp     (rd_resp)
    );

    // Bits above REG_W and unused status lanes are intentionally dropped
    assign unused_in = ^{wr_data, wr_strb, stat_i};

    always_comb begin
        wmask = '0;
        for (int b = 0; b < REG_W; b++) wmask[b] = wr_strb[b/8];
    end

    assign apply_wr  = wr_en && wr_hit && (wr_idx == APPLY_IDX) && wr_strb[0];
    assign apply_req = apply_wr && wr_data[APPLY_REQ_BIT] && !pending;
    assign apply_go  = imm_q || (pending && sof_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < CTRL_CNT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CTRL_CNT; i++) begin
                if (wr_en && wr_hit && (wr_idx == IDX_W'(i)))
                    shadow[i] <= (shadow[i] & ~wmask) | (wr_data[REG_W-1:0] & wmask);
                // Non-blocking copy takes the pre-write shadow on a same-cycle write
                if (apply_go)
                    active[i] <= shadow[i];
            end
        end
    end

    // A sof_i during the commit cycle is not seen: pending is still 0 then
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode        <= 1'b0;
            pending     <= 1'b0;
            imm_q       <= 1'b0;
            apply_stb_o <= 1'b0;
        end else begin
            if (apply_wr)
                mode <= wr_data[APPLY_MODE_BIT];
            imm_q <= apply_req && !wr_data[APPLY_MODE_BIT];
            if (apply_req && wr_data[APPLY_MODE_BIT])
                pending <= 1'b1;
            else if (pending && sof_i)
                pending <= 1'b0;
            apply_stb_o <= apply_go;
        end
    end

    for (genvar g = 0; g < CTRL_CNT; g++) begin : g_ctrl
        assign ctrl_o[g*REG_W +: REG_W] = active[g];
    end

    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            for (int i = 0; i < CTRL_CNT; i++)
                if (rd_idx == IDX_W'(i)) rd_data = 32'(shadow[i]);
            if (rd_idx == APPLY_IDX) begin
                rd_data[APPLY_MODE_BIT] = mode;
                rd_data[APPLY_PEND_BIT] = pending;
            end
            for (int s = 0; s < STAT_CNT; s++)
                if (rd_idx == IDX_W'(CTRL_CNT + 1 + s)) rd_data = stat_i[s*32 +: 32];
        end
    end

    assign rd_resp = rd_hit ? RESP_OKAY : RESP_SLVERR;

endmodule

// File: tb/tb_px_ss_csr_bank.sv
// Scoreboard bench for px_ss_csr_bank (CTRL_CNT=6, STAT_CNT=2, REG_W=12).
module tb_px_ss_csr_bank;
    import px_ss_csr_bank_pkg::*;

    localparam int CC = 6;
    localparam int SC = 2;
    localparam int RW = 12;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [31:0]       awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]        wstrb = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic              bready = 1'b1, rready = 1'b1, sof_i = 1'b0;
    logic              awready, wready, arready, bvalid, rvalid, apply_stb_o;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [SC*32-1:0]  stat_i = {32'hDEAD_0002, 32'hCAFE_0001};
    logic [CC*RW-1:0]  ctrl_o;
    logic [CC*RW-1:0]  ctrl_at_b = '0;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int s0;
    logic [1:0]  sb_b[$];
    logic [33:0] sb_r[$];

    always #5 clk_i = ~clk_i;

    px_ss_csr_bank #(
        .BASE_ADDR (32'h0000_0000),
        .CTRL_CNT  (CC),
        .STAT_CNT  (SC),
        .REG_W     (RW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .csr_awaddr  (awaddr),
        .csr_awvalid (awvalid),
        .csr_awready (awready),
        .csr_wdata   (wdata),
        .csr_wstrb   (wstrb),
        .csr_wvalid  (wvalid),
        .csr_wready  (wready),
        .csr_bresp   (bresp),
        .csr_bvalid  (bvalid),
        .csr_bready  (bready),
        .csr_araddr  (araddr),
        .csr_arvalid (arvalid),
        .csr_arready (arready),
        .csr_rdata   (rdata),
        .csr_rresp   (rresp),
        .csr_rvalid  (rvalid),
        .csr_rready  (rready),
        .sof_i       (sof_i),
        .stat_i      (stat_i),
        .ctrl_o      (ctrl_o),
        .apply_stb_o (apply_stb_o)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic logic [RW-1:0] ctl(input int i);
        return ctrl_o[i*RW +: RW];
    endfunction

    always @(negedge clk_i) if (apply_stb_o) stb_cnt++;

    // Monitor: pops the expected response whenever a B or R handshake is due
    always @(negedge clk_i) begin
        if (rst_i && bvalid && bready) begin
            if (sb_b.size() == 0) timeout("b_unexpected");
            else chk("bresp", bresp, sb_b.pop_front());
        end
        if (rst_i && rvalid && rready) begin
            if (sb_r.size() == 0) timeout("r_unexpected");
            else begin
                logic [33:0] e;
                e = sb_r.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rresp", rresp, e[33:32]);
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er, input logic sof);
        bit ad, wd, ah, wh;
        int n;
        sb_b.push_back(er);
        @(posedge clk_i); #1;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; sof_i = sof;
        ad = 0; wd = 0; n = 0;
        while (!(ad && wd) && n < 20) begin
            @(negedge clk_i);
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(posedge clk_i); #1;
            sof_i = 1'b0;
            if (ah) begin awvalid = 1'b0; ad = 1; end
            if (wh) begin wvalid = 1'b0; wd = 1; end
            n++;
        end
        if (!(ad && wd)) begin
            awvalid = 1'b0; wvalid = 1'b0;
            timeout("wr_handshake");
            return;
        end
        n = 0;
        do begin @(negedge clk_i); n++; end while (!bvalid && n < 20);
        if (!bvalid) timeout("wr_bvalid");
        ctrl_at_b = ctrl_o;
        @(posedge clk_i); #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        bit h;
        int n;
        sb_r.push_back({er, ed});
        @(posedge clk_i); #1;
        araddr = a; arvalid = 1'b1;
        n = 0; h = 0;
        while (!h && n < 20) begin
            @(negedge clk_i); h = arready;
            @(posedge clk_i); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!h) begin timeout("rd_handshake"); return; end
        n = 0;
        do begin @(negedge clk_i); n++; end while (!rvalid && n < 20);
        if (!rvalid) timeout("rd_rvalid");
        @(posedge clk_i); #1;
        chk("rdata_idle", rdata, 32'h0);
    endtask

    task automatic wr_split(input logic aw_first, input logic [31:0] a, input logic [31:0] d);
        sb_b.push_back(RESP_OKAY);
        bready = 1'b0;
        @(posedge clk_i); #1;
        if (aw_first) begin awaddr = a; awvalid = 1'b1; end
        else begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
        @(negedge clk_i);
        chk("split_first_ready", aw_first ? awready : wready, 1);
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk_i);
        chk("split_held_ready", aw_first ? awready : wready, 0);
        chk("split_other_ready", aw_first ? wready : awready, 1);
        @(posedge clk_i);
        @(posedge clk_i); #1;
        if (aw_first) begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
        else begin awaddr = a; awvalid = 1'b1; end
        @(negedge clk_i);
        chk("split_bvalid_early", bvalid, 0);
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("split_bvalid_lat", bvalid, 1);
        repeat (2) begin
            @(negedge clk_i);
            chk("split_awready_blk", awready, 0);
            chk("split_wready_blk", wready, 0);
        end
        @(posedge clk_i); #1;
        bready = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int bseen;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_ctrl", ctrl_o, '0);
        chk("rst_stb", apply_stb_o, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_ready", {awready, wready, arready}, 3'b111);

        // immediate apply
        wr(32'h00, 32'h1234, 4'hF, RESP_OKAY, 1'b0);
        rd(32'h00, 32'h234, RESP_OKAY);
        s0 = stb_cnt;
        wr(32'h18, 32'h1, 4'hF, RESP_OKAY, 1'b0);
        chk("imm_ctrl_at_b", ctrl_at_b[RW-1:0], 0);
        chk("imm_ctrl0", ctl(0), 12'h234);
        chk("imm_stb", apply_stb_o, 1);
        repeat (3) @(posedge clk_i); #1;
        chk("imm_stb_count", stb_cnt - s0, 1);
        rd(32'h18, 32'h0, RESP_OKAY);

        // AW/W ordering
        wr_split(1'b1, 32'h04, 32'h0555);
        wr_split(1'b0, 32'h0C, 32'h0AAA);
        rd(32'h04, 32'h555, RESP_OKAY);
        rd(32'h0C, 32'hAAA, RESP_OKAY);

        // frame-synchronous apply
        wr(32'h18, 32'h2, 4'hF, RESP_OKAY, 1'b0);
        wr(32'h08, 32'hBEEF, 4'hF, RESP_OKAY, 1'b0);
        s0 = stb_cnt;
        wr(32'h18, 32'h3, 4'hF, RESP_OKAY, 1'b1);
        rd(32'h18, 32'h6, RESP_OKAY);
        wr(32'h18, 32'h3, 4'hF, RESP_OKAY, 1'b0);
        chk("sync_ctrl_hold", ctl(2), 0);
        chk("sync_no_stb", stb_cnt - s0, 0);
        @(posedge clk_i); #1 sof_i = 1'b1;
        @(negedge clk_i);
        chk("sync_pre_sof", ctl(2), 0);
        @(posedge clk_i); #1 sof_i = 1'b0;
        chk("sync_ctrl2", ctl(2), 12'hEEF);
        chk("sync_stb", apply_stb_o, 1);
        @(posedge clk_i); #1 sof_i = 1'b1;
        @(posedge clk_i); #1 sof_i = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        chk("sync_stb_count", stb_cnt - s0, 1);
        rd(32'h18, 32'h2, RESP_OKAY);

        // strobes and width
        wr(32'h10, 32'hFFFF_FFFF, 4'b0010, RESP_OKAY, 1'b0);
        rd(32'h10, 32'h0F00, RESP_OKAY);
        wr(32'h14, 32'hFFFF_FFFF, 4'b0100, RESP_OKAY, 1'b0);
        rd(32'h14, 32'h0, RESP_OKAY);

        // out-of-range, status and read-only writes
        rd(32'h1000, 32'h0, RESP_SLVERR);
        s0 = stb_cnt;
        wr(32'h1000, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 1'b0);
        rd(32'h24, 32'h0, RESP_SLVERR);
        rd(32'h20, 32'hDEAD_0002, RESP_OKAY);
        wr(32'h1C, 32'h1234, 4'hF, RESP_OKAY, 1'b0);
        rd(32'h1C, 32'hCAFE_0001, RESP_OKAY);
        rd(32'h00, 32'h234, RESP_OKAY);
        rd(32'h08, 32'hEEF, RESP_OKAY);
        rd(32'h18, 32'h2, RESP_OKAY);
        chk("slverr_no_stb", stb_cnt - s0, 0);

        // reset between AW and W handshakes
        @(posedge clk_i); #1 awaddr = 32'h04; awvalid = 1'b1;
        @(posedge clk_i); #1 awvalid = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_aw_held", awready, 0);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        bseen = 0;
        repeat (5) begin @(negedge clk_i); if (bvalid) bseen++; end
        chk("rst_mid_no_b", bseen, 0);
        chk("rst_mid_ctrl", ctrl_o, '0);
        chk("rst_mid_stb", apply_stb_o, 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_ready", {awready, wready, arready}, 3'b111);
        rd(32'h18, 32'h0, RESP_OKAY);
        rd(32'h00, 32'h0, RESP_OKAY);
        wr(32'h04, 32'h0ABC, 4'hF, RESP_OKAY, 1'b0);
        rd(32'h04, 32'hABC, RESP_OKAY);

        repeat (2) @(posedge clk_i);
        chk("sb_b_empty", sb_b.size(), 0);
        chk("sb_r_empty", sb_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/px_ss_csr_bank.md
# px_ss_csr_bank

Parametrised AXI4-Lite control/status register bank for image-processing blocks; the next generation of the pixel-subsampler CSR. It generalises to CTRL_CNT shadowed control registers of REG_W bits and STAT_CNT read-only status registers. It adds independent AW/W acceptance, SLVERR decoding and an apply mechanism that is either immediate or frame-synchronous. It sits between the system AXI4-Lite interconnect and a datapath block's configuration inputs.

## Interface
- BASE_ADDR, 32'h0000_0000, byte base address of the bank
- CTRL_CNT, 6, number of shadowed control registers (1..64)
- STAT_CNT, 2, number of read-only status registers (0..64)
- REG_W, 16, width of each control register (1..32)
- clk_i  input  1  clock; the only clock
- rst_i  input  1  reset, asynchronous, active-low
- csr_i  axi4_lite_if.slave  32-bit data/address  register access
- sof_i  input  1  start-of-frame pulse from the video stream; used by the synchronous apply
- stat_i  input  STAT_CNT x 32  status values, sampled at read
- ctrl_o  output  CTRL_CNT x REG_W  active (applied) control values
- apply_stb_o  output  1  one-cycle pulse, asserted in the same cycle that ctrl_o takes new values

## Operation
- Register map, word index = (addr - BASE_ADDR) >> 2:
  - 0..CTRL_CNT-1: control shadow registers, RW.
  - CTRL_CNT: APPLY register.
    - bit0 is write-1 to request apply and reads 0.
    - bit1 is MODE, RW: 0 = immediate, 1 = wait for sof_i.
    - bit2 is PENDING, RO.
  - CTRL_CNT+1 .. CTRL_CNT+STAT_CNT: status, RO.
- Out-of-range or unaligned-below-base addresses:
  - Respond SLVERR (2'b10).
  - Writes have no effect; reads return 0.
- Writes to RO indices return OKAY and are ignored.
- Byte strobes apply per lane. Lanes wholly above REG_W are ignored. Bits above REG_W read as 0.
- Apply, immediate mode: on the write commit cycle+1, ctrl_o <= shadow and apply_stb_o = 1.
- Apply, sync mode: the commit sets PENDING. On the first sof_i with PENDING=1, ctrl_o <= shadow, apply_stb_o = 1 in the next cycle, and PENDING clears.
- A repeated apply request while PENDING=1 has no additional effect.
- A shadow write committing in the same cycle as the copy: the copy uses the pre-write shadow value.
- A sof_i in the same cycle as the apply commit is ignored; the bank waits for the next sof_i.
- Clearing MODE while PENDING=1 leaves PENDING set until the next sof_i.

## Timing
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W may arrive in either order or together. Each is latched independently.
  - The write commits on the first cycle both are held. bvalid rises on that same edge and stays asserted until bready.
  - The held flags clear at commit.
  - Minimum write latency: AW+W handshake at cycle N, bvalid at N+1.
- Read channel:
  - arready = !rvalid. rvalid and rdata are registered one cycle after the AR handshake.
  - rdata holds until the R handshake, then returns to 0.
  - stat_i is sampled on the handshake cycle.
- Reads and writes proceed independently and concurrently.
- Reset values:
  - ctrl_o, shadow, MODE, PENDING, apply_stb_o, bvalid, rvalid, rdata, bresp and rresp are all 0.
  - awready, wready and arready are 1 after reset release.
- Reset asserted mid-transaction aborts it: all held state and pending responses clear.

## Structure
- Package px_ss_csr_bank_pkg holds:
  - AXI response codes RESP_OKAY and RESP_SLVERR.
  - APPLY bit positions APPLY_REQ_BIT, APPLY_MODE_BIT and APPLY_PEND_BIT.
  - An address-decode function returning index and in-range flag.
- Sub-module px_ss_axil_fe handles the AW/W/B/AR/R handshakes. It exports write-commit (index, data, strobe) and read-request (index), and takes read data and resp back.
- The top holds the shadow/active registers, the apply logic and the read mux.

## Test plan
- Immediate apply with REG_W=16:
  - Write 0x1234 to index 0, then 0x1 to APPLY.
  - ctrl_o[0]=0x1234 one cycle after the APPLY bvalid edge, with a single apply_stb_o pulse.
- AW three cycles before W, then W before AW:
  - Both writes land correctly, with bvalid exactly one cycle after the later handshake.
  - awready/wready stay low while bvalid is pending with bready=0.
- Sync apply:
  - MODE=1, write 0xBEEF to index 2, then request apply.
  - PENDING reads 1 and ctrl_o is unchanged until sof_i; on sof_i, ctrl_o[2]=0xBEEF and apply_stb_o pulses once.
  - sof_i coincident with the commit does not apply.
- Strobes and width, REG_W=12:
  - Write 0xFFFF_FFFF with wstrb=4'b0010.
  - Reads back 0x0F00.
- Read 0x0000_1000 beyond the map:
  - rresp=SLVERR, rdata=0.
  - The same-address write gives bresp=SLVERR and leaves all registers unchanged.
- Assert rst_i low between the AW and W handshakes:
  - After release, no bvalid is issued.
  - All outputs are at their reset values and the next full write completes normally.
